// File: rtl/multicycle_mem_arbiter_if.sv
// Bus bundle for the multicycle memory arbiter:
// core and aux request ports plus the shared memory port.
interface multicycle_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  core_req_valid;
  logic                  core_req_ready;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic                  core_write;
  logic [31:0]           core_wdata;
  logic [2:0]            core_format;
  logic                  core_done;
  logic [31:0]           core_rdata;

  logic                  aux_req_valid;
  logic                  aux_req_ready;
  logic [ADDR_WIDTH-1:0] aux_addr;
  logic                  aux_write;
  logic [31:0]           aux_wdata;
  logic [2:0]            aux_format;
  logic                  aux_done;
  logic [31:0]           aux_rdata;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_write;
  logic [31:0]           mem_wdata;
  logic [2:0]            mem_format;
  logic                  mem_resp_valid;
  logic [31:0]           mem_rdata;

  logic                  timeout_error;

  modport slave (
    input  core_req_valid, core_addr, core_write,
    input  core_wdata, core_format,
    output core_req_ready, core_done, core_rdata,
    input  aux_req_valid, aux_addr, aux_write,
    input  aux_wdata, aux_format,
    output aux_req_ready, aux_done, aux_rdata,
    output mem_req_valid, mem_addr, mem_write,
    output mem_wdata, mem_format,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output timeout_error
  );

  modport master (
    output core_req_valid, core_addr, core_write,
    output core_wdata, core_format,
    input  core_req_ready, core_done, core_rdata,
    output aux_req_valid, aux_addr, aux_write,
    output aux_wdata, aux_format,
    input  aux_req_ready, aux_done, aux_rdata,
    input  mem_req_valid, mem_addr, mem_write,
    input  mem_wdata, mem_format,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  timeout_error
  );
endinterface

// File: rtl/multicycle_mem_arbiter.sv
// Two-requester memory arbiter for the multicycle core:
// one outstanding transaction, round-robin, with timeout.
module multicycle_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clock,
  input logic reset,
  multicycle_mem_arbiter_if.slave bus
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic GR_CORE = 1'b0;
  localparam logic GR_AUX  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [31:0]           r_wdata;
  logic [2:0]            r_format;
  logic [CW-1:0]         r_cnt;
  logic                  r_core_done;
  logic                  r_aux_done;
  logic                  r_timeout;
  logic [31:0]           r_core_rdata;
  logic [31:0]           r_aux_rdata;

  logic w_pick_core;
  logic w_pick_aux;
  logic w_accept;
  logic w_expire;
  logic w_complete;
  logic w_abort;
  logic w_finish;

  // Grant: a lone requester wins, a tie goes to whoever did not win last
  always_comb begin
    w_pick_core = 1'b0;
    w_pick_aux  = 1'b0;
    if (r_state == S_IDLE && reset) begin
      if (bus.core_req_valid && bus.aux_req_valid) begin
        w_pick_core = (r_grant == GR_AUX);
        w_pick_aux  = (r_grant == GR_CORE);
      end else begin
        w_pick_core = bus.core_req_valid;
        w_pick_aux  = bus.aux_req_valid;
      end
    end
  end

  assign w_accept = w_pick_core | w_pick_aux;
  assign w_expire = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_finish = w_complete | w_abort;

  // Next state; a response on the expiry cycle counts as completion
  always_comb begin
    w_next     = r_state;
    w_complete = 1'b0;
    w_abort    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_expire) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (bus.mem_req_ready) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_resp_valid) begin
          w_complete = 1'b1;
          w_next     = S_IDLE;
        end else if (w_expire) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Capture the winner's request; r_grant doubles as last_grant
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_grant  <= GR_AUX;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_format <= '0;
    end else if (w_accept) begin
      r_grant  <= w_pick_aux;
      r_addr   <= w_pick_aux ? bus.aux_addr : bus.core_addr;
      r_write  <= w_pick_aux ? bus.aux_write : bus.core_write;
      r_wdata  <= w_pick_aux ? bus.aux_wdata : bus.core_wdata;
      r_format <= w_pick_aux ? bus.aux_format : bus.core_format;
    end
  end

  // Cycles spent in ISSUE+WAIT for the current transaction
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 r_cnt <= '0;
    else if (w_accept)          r_cnt <= '0;
    else if (r_state != S_IDLE) r_cnt <= r_cnt + CW'(1);
  end

  // Completion pulses; rdata holds between pulses, zero on abort
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_core_done  <= 1'b0;
      r_aux_done   <= 1'b0;
      r_timeout    <= 1'b0;
      r_core_rdata <= '0;
      r_aux_rdata  <= '0;
    end else begin
      r_core_done <= w_finish && (r_grant == GR_CORE);
      r_aux_done  <= w_finish && (r_grant == GR_AUX);
      r_timeout   <= w_abort;
      if (w_finish && r_grant == GR_CORE)
        r_core_rdata <= w_abort ? 32'd0 : bus.mem_rdata;
      if (w_finish && r_grant == GR_AUX)
        r_aux_rdata <= w_abort ? 32'd0 : bus.mem_rdata;
    end
  end

  assign bus.core_req_ready = w_pick_core;
  assign bus.aux_req_ready  = w_pick_aux;
  assign bus.mem_req_valid  = (r_state == S_ISSUE);
  assign bus.mem_addr       = r_addr;
  assign bus.mem_write      = r_write;
  assign bus.mem_wdata      = r_wdata;
  assign bus.mem_format     = r_format;
  assign bus.core_done      = r_core_done;
  assign bus.core_rdata     = r_core_rdata;
  assign bus.aux_done       = r_aux_done;
  assign bus.aux_rdata      = r_aux_rdata;
  assign bus.timeout_error  = r_timeout;

endmodule

// File: tb/tb_multicycle_mem_arbiter.sv
// Bench for multicycle_mem_arbiter: directed stimulus,
// transaction-level model checked every cycle, plus literal checks.
module tb_multicycle_mem_arbiter;

  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  multicycle_mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  multicycle_mem_arbiter #(
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // model state: 0 idle, 1 request offered, 2 awaiting response
  int          m_phase;
  int          m_age;
  logic        m_owner;
  logic        m_last;
  logic [31:0] m_addr;
  logic        m_write;
  logic [31:0] m_wdata;
  logic [2:0]  m_fmt;
  logic        m_cd, m_ad, m_to;
  logic [31:0] m_cr, m_ar;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_age = 0; m_owner = 1'b0; m_last = 1'b1;
    m_addr = '0; m_write = 1'b0; m_wdata = '0; m_fmt = '0;
    m_cd = 1'b0; m_ad = 1'b0; m_to = 1'b0;
    m_cr = '0; m_ar = '0;
  endtask

  task automatic m_end(input logic [31:0] d, input logic to);
    if (m_owner) begin m_ad = 1'b1; m_ar = d; end
    else begin m_cd = 1'b1; m_cr = d; end
    m_to = to;
    m_phase = 0;
  endtask

  task automatic model_check();
    logic wc, wa;
    if (!rst) m_reset();
    wc = 1'b0; wa = 1'b0;
    if (rst && m_phase == 0) begin
      if (bus.core_req_valid && bus.aux_req_valid) begin
        wc = m_last; wa = !m_last;
      end else begin
        wc = bus.core_req_valid; wa = bus.aux_req_valid;
      end
    end
    chk("core_req_ready", 32'(bus.core_req_ready), 32'(wc));
    chk("aux_req_ready", 32'(bus.aux_req_ready), 32'(wa));
    chk("mem_req_valid", 32'(bus.mem_req_valid), 32'(m_phase == 1));
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("mem_write", 32'(bus.mem_write), 32'(m_write));
    chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("mem_format", 32'(bus.mem_format), 32'(m_fmt));
    chk("core_done", 32'(bus.core_done), 32'(m_cd));
    chk("aux_done", 32'(bus.aux_done), 32'(m_ad));
    chk("core_rdata", bus.core_rdata, m_cr);
    chk("aux_rdata", bus.aux_rdata, m_ar);
    chk("timeout_error", 32'(bus.timeout_error), 32'(m_to));
    if (rst) begin
      m_cd = 1'b0; m_ad = 1'b0; m_to = 1'b0;
      case (m_phase)
        0: if (wc || wa) begin
          m_owner = wa; m_last = wa;
          m_addr  = wa ? bus.aux_addr : bus.core_addr;
          m_write = wa ? bus.aux_write : bus.core_write;
          m_wdata = wa ? bus.aux_wdata : bus.core_wdata;
          m_fmt   = wa ? bus.aux_format : bus.core_format;
          m_phase = 1; m_age = 0;
        end
        1: begin
          m_age++;
          if (m_age == T) m_end(32'd0, 1'b1);
          else if (bus.mem_req_ready) m_phase = 2;
        end
        default: begin
          m_age++;
          if (bus.mem_resp_valid) m_end(bus.mem_rdata, 1'b0);
          else if (m_age == T) m_end(32'd0, 1'b1);
        end
      endcase
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.core_req_valid = 0; bus.core_addr = '0; bus.core_write = 0;
    bus.core_wdata = '0; bus.core_format = 3'b010;
    bus.aux_req_valid = 0; bus.aux_addr = '0; bus.aux_write = 0;
    bus.aux_wdata = '0; bus.aux_format = 3'b010;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = '0;
  endtask

  task automatic core_rd(input logic [31:0] a);
    bus.core_req_valid = 1; bus.core_addr = a;
    bus.core_write = 0; bus.core_format = 3'b010;
  endtask

  task automatic do_reset();
    rst = 0;
    cyc(); cyc();
    rst = 1;
  endtask

  int n_hi;
  logic [5:0] rr_exp;

  initial begin
    quiet();
    m_reset();
    cyc();
    #2;
    chk("rst_mem_valid", 32'(bus.mem_req_valid), 0);
    chk("rst_core_done", 32'(bus.core_done), 0);
    rst = 1;
    cyc();

    // core read 0x100, ready cycle 1, response cycle 2
    core_rd(32'h100);
    #1 chk("t1_ready", 32'(bus.core_req_ready), 1);
    cyc();
    bus.core_req_valid = 0; bus.mem_req_ready = 1;
    #1 chk("t1_mvalid", 32'(bus.mem_req_valid), 1);
    chk("t1_maddr", bus.mem_addr, 32'h100);
    cyc();
    bus.mem_req_ready = 0; bus.mem_resp_valid = 1;
    bus.mem_rdata = 32'hDEADBEEF;
    #1 chk("t1_mvalid_wait", 32'(bus.mem_req_valid), 0);
    cyc();
    quiet();
    chk("t1_done", 32'(bus.core_done), 1);
    chk("t1_rdata", bus.core_rdata, 32'hDEADBEEF);
    chk("t1_aux_done", 32'(bus.aux_done), 0);
    cyc();
    chk("t1_done_pulse", 32'(bus.core_done), 0);

    // round robin from reset: core, aux, core, aux, core, aux
    do_reset();
    rr_exp = 6'b101010;
    for (int i = 0; i < 6; i++) begin
      bus.mem_resp_valid = 0;
      bus.core_req_valid = 1; bus.core_addr = 32'h10 * i;
      bus.aux_req_valid = 1; bus.aux_addr = 32'h8000 + i;
      #1;
      chk("rr_core_ready", 32'(bus.core_req_ready), 32'(!rr_exp[i]));
      chk("rr_aux_ready", 32'(bus.aux_req_ready), 32'(rr_exp[i]));
      cyc();
      bus.core_req_valid = 0; bus.aux_req_valid = 0;
      bus.mem_req_ready = 1;
      cyc();
      bus.mem_req_ready = 0; bus.mem_resp_valid = 1;
      bus.mem_rdata = 32'hA0 + i;
      cyc();
      if (rr_exp[i]) chk("rr_aux_rdata", bus.aux_rdata, 32'hA0 + i);
      else chk("rr_core_rdata", bus.core_rdata, 32'hA0 + i);
    end
    quiet();
    cyc();

    // aux write with memory stalling four cycles
    bus.aux_req_valid = 1; bus.aux_addr = 32'h2000; bus.aux_write = 1;
    bus.aux_wdata = 32'h55AA; bus.aux_format = 3'b001;
    #1 chk("t3_ready", 32'(bus.aux_req_ready), 1);
    cyc();
    quiet();
    n_hi = 0;
    for (int k = 0; k < 5; k++) begin
      bus.mem_req_ready = (k == 4);
      #1;
      if (bus.mem_req_valid) n_hi++;
      chk("t3_addr", bus.mem_addr, 32'h2000);
      chk("t3_wdata", bus.mem_wdata, 32'h55AA);
      chk("t3_fmt", 32'(bus.mem_format), 1);
      chk("t3_write", 32'(bus.mem_write), 1);
      cyc();
    end
    bus.mem_req_ready = 0; bus.mem_resp_valid = 1;
    bus.mem_rdata = 32'h1234;
    #1;
    if (bus.mem_req_valid) n_hi++;
    chk("t3_valid_cycles", 32'(n_hi), 5);
    cyc();
    quiet();
    chk("t3_done", 32'(bus.aux_done), 1);
    chk("t3_rdata", bus.aux_rdata, 32'h1234);
    chk("t3_core_done", 32'(bus.core_done), 0);
    cyc();

    // memory never responds: abort 8 cycles after entering ISSUE
    core_rd(32'h300);
    cyc();
    quiet();
    bus.mem_req_ready = 1;
    cyc();
    bus.mem_req_ready = 0;
    for (int k = 2; k <= 8; k++) begin
      #1 chk("t4_no_done", 32'(bus.core_done), 0);
      cyc();
    end
    chk("t4_done", 32'(bus.core_done), 1);
    chk("t4_rdata", bus.core_rdata, 32'd0);
    chk("t4_timeout", 32'(bus.timeout_error), 1);
    core_rd(32'h304);
    cyc();
    quiet();
    bus.mem_req_ready = 1;
    #1 chk("t4_next_addr", bus.mem_addr, 32'h304);
    cyc();
    bus.mem_req_ready = 0; bus.mem_resp_valid = 1;
    bus.mem_rdata = 32'hCAFEF00D;
    cyc();
    quiet();
    chk("t4_next_done", 32'(bus.core_done), 1);
    chk("t4_next_rdata", bus.core_rdata, 32'hCAFEF00D);
    chk("t4_next_to", 32'(bus.timeout_error), 0);
    cyc();

    // response lands exactly on the expiry cycle
    core_rd(32'h400);
    cyc();
    quiet();
    bus.mem_req_ready = 1;
    cyc();
    bus.mem_req_ready = 0;
    for (int k = 2; k < 8; k++) cyc();
    bus.mem_resp_valid = 1; bus.mem_rdata = 32'h12345678;
    cyc();
    quiet();
    chk("t6_done", 32'(bus.core_done), 1);
    chk("t6_rdata", bus.core_rdata, 32'h12345678);
    chk("t6_to", 32'(bus.timeout_error), 0);
    cyc();

    // asynchronous reset while waiting for the response
    core_rd(32'h500);
    cyc();
    quiet();
    bus.mem_req_ready = 1;
    cyc();
    bus.mem_req_ready = 0;
    #1 rst = 0;
    #1;
    chk("t5_mvalid", 32'(bus.mem_req_valid), 0);
    chk("t5_maddr", bus.mem_addr, 32'd0);
    chk("t5_rdata", bus.core_rdata, 32'd0);
    cyc();
    rst = 1;
    bus.mem_resp_valid = 1; bus.mem_rdata = 32'h99;
    cyc();
    quiet();
    chk("t5_no_done", 32'(bus.core_done), 0);
    chk("t5_no_aux", 32'(bus.aux_done), 0);
    chk("t5_rdata_late", bus.core_rdata, 32'd0);
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_mem_arbiter.md
Name:
multicycle_mem_arbiter

Overview:
Shares the single memory port of the multicycle core between two requesters: the core itself (instruction fetch and data accesses) and an auxiliary master (program loader/debug). One transaction is outstanding at a time, with round-robin grant on contention. A timeout recovers from a hung memory. It sits between the multicycle datapath/ctlpath and the memory model.

Parameters:
ADDR_WIDTH, 32, address width of all ports
TIMEOUT_CYCLES, 255, max cycles in ISSUE+WAIT before abort; must be >=1

Ports:
clock  in  1  system clock
reset  in  1  asynchronous reset, active-low (asserted when 0)
core_req_valid  in  1  core request pending
core_req_ready  out  1  core request accepted this cycle
core_addr  in  ADDR_WIDTH  core address
core_write  in  1  1=write, 0=read
core_wdata  in  32  core write data
core_format  in  3  funct3-style size/sign (010=word)
core_done  out  1  one-cycle completion pulse
core_rdata  out  32  read data, valid while core_done=1
aux_req_valid  in  1  aux request pending
aux_req_ready  out  1  aux request accepted this cycle
aux_addr  in  ADDR_WIDTH  aux address
aux_write  in  1  1=write, 0=read
aux_wdata  in  32  aux write data
aux_format  in  3  aux size/sign
aux_done  out  1  one-cycle completion pulse
aux_rdata  out  32  read data, valid while aux_done=1
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_WIDTH  latched address
mem_write  out  1  latched write flag
mem_wdata  out  32  latched write data
mem_format  out  3  latched format
mem_resp_valid  in  1  memory response (reads and writes)
mem_rdata  in  32  memory read data
timeout_error  out  1  one-cycle pulse, with the done pulse of an aborted transaction

Behaviour:
- Reset (reset=0, async): state=IDLE, last_grant=AUX (so core wins first tie), all outputs 0, latched fields 0, timeout counter 0.
- States: IDLE, ISSUE, WAIT.
- IDLE: grant is combinational. One valid wins outright. If both are valid, the winner is the requester not equal to last_grant. The winner's *_req_ready=1 this cycle. Its addr/write/wdata/format, the grant id and last_grant are latched. Next state ISSUE. *_req_ready is only ever 1 in IDLE.
- ISSUE: mem_req_valid=1, mem_* driven from latches. If mem_req_ready=1, next state WAIT.
- WAIT: mem_req_valid=0. If mem_resp_valid=1, next cycle: the granted *_done=1, *_rdata=registered mem_rdata (writes: rdata=mem_rdata, ignored by requester). State returns to IDLE.
- Request handshake is valid/ready. A requester may change or drop valid after acceptance. The core must not re-request before its done pulse.
- Latency without stalls: accept cycle 0, mem_req_valid cycle 1, ready cycle 1, resp cycle 2, done cycle 3. In cycle 3 the state is IDLE, so a new accept is possible in cycle 3.
- Non-granted *_done is 0. *_rdata holds its last value between pulses. *_done is never 1 for both requesters.
- Timeout: the counter clears on entering ISSUE and increments each cycle in ISSUE/WAIT. When it reaches TIMEOUT_CYCLES without completion: next cycle granted *_done=1, *_rdata=0, timeout_error=1. State goes to IDLE and mem_req_valid drops.
- mem_resp_valid in IDLE/ISSUE is ignored. mem_req_ready outside ISSUE is ignored.
- Completion and timeout in the same cycle: the completion wins, with no error.
- Reset mid-transaction: immediate return to IDLE, no done pulse, and the in-flight memory request is abandoned.

Test Plan:
- Core read 0x100, mem_req_ready cycle 1, resp cycle 2 with 0xDEADBEEF -> core_req_ready cycle 0, mem_addr=0x100, core_done+core_rdata=0xDEADBEEF cycle 3, aux_done=0.
- Both valid from reset, each issues 3 requests -> grant order core, aux, core, aux, core, aux.
- Aux write 0x2000 data 0x55AA, format 001, mem_req_ready held low 4 cycles -> mem_* stable throughout, mem_req_valid high 5 cycles, aux_done after resp.
- TIMEOUT_CYCLES=8, memory never responds -> done with rdata=0 and timeout_error exactly 8 cycles after entering ISSUE; next request proceeds normally.
- Async reset asserted in WAIT -> outputs 0 immediately; a late mem_resp_valid after reset release produces no done.
- Resp arriving on the timeout-expiry cycle -> normal done with mem_rdata, timeout_error=0.
